gs_mix_dac: RTL



---
 rtl/gs_mix_dac_if.sv | 21 ++
 rtl/gs_mix_dac.sv | 138 +++++++++++++
 2 files changed

// File: rtl/gs_mix_dac_if.sv
// GS channel samples/volumes in, stereo PCM mix and 1-bit sigma-delta streams out.
// master drives the channel registers; slave is the mixer.
interface gs_mix_dac_if;
  logic               ena;
  logic [7:0]         dac0, dac1, dac2, dac3;
  logic [5:0]         vol0, vol1, vol2, vol3;
  logic signed [14:0] pcm_l, pcm_r;
  logic               sample_valid;
  logic               busy;
  logic               dac_l, dac_r;

  modport master (
    output ena, dac0, dac1, dac2, dac3, vol0, vol1, vol2, vol3,
    input  pcm_l, pcm_r, sample_valid, busy, dac_l, dac_r
  );

  modport slave (
    input  ena, dac0, dac1, dac2, dac3, vol0, vol1, vol2, vol3,
    output pcm_l, pcm_r, sample_valid, busy, dac_l, dac_r
  );
endinterface

// File: rtl/gs_mix_dac.sv
// Volume-scaled stereo mix of the four GS channels via a serial shift-add MAC, plus first-order sigma-delta DACs.
// Latency: tick -> 24 MUL cycles -> UPDATE (sample_valid) -> new pcm one cycle later; sigma-delta follows pcm next cycle.
// No backpressure: sample_valid is a one-cycle strobe, inputs are snapshotted on tick and never stalled.
module gs_mix_dac #(
  parameter int unsigned SAMPLE_DIV = 512
) (
  input  logic        clk32,
  input  logic        rst,
  gs_mix_dac_if.slave mix
);

  typedef enum logic [1:0] {IDLE, MUL, UPDATE} state_t;

  state_t             state, state_nxt;
  logic [15:0]        div_cnt;
  logic               tick;
  logic signed [7:0]  s_sh   [4];
  logic [5:0]         vol_sh [4];
  logic [1:0]         ch;
  logic [2:0]         bit_idx;
  logic               mul_last;
  logic               add_en;
  logic signed [7:0]  s_cur;
  logic signed [15:0] addend;
  logic signed [15:0] acc_l, acc_r;
  logic signed [14:0] pcm_l_q, pcm_r_q;
  logic [14:0]        u_l, u_r;
  logic [14:0]        sd_acc_l, sd_acc_r;
  logic               dac_l_q, dac_r_q;

  assign tick     = (div_cnt == 16'(SAMPLE_DIV - 1));
  assign mul_last = (ch == 2'd3) && (bit_idx == 3'd5);

  always_ff @(posedge clk32) begin
    if (rst || tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + 16'd1;
  end

  always_ff @(posedge clk32) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (tick) state_nxt = MUL;
      MUL:     if (mul_last) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One volume bit per cycle: the partial product is the sample shifted by the bit position.
  always_comb begin
    s_cur  = s_sh[ch];
    add_en = vol_sh[ch][bit_idx];
    addend = {{8{s_cur[7]}}, s_cur} <<< bit_idx;
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      acc_l   <= '0;
      acc_r   <= '0;
      ch      <= '0;
      bit_idx <= '0;
      for (int i = 0; i < 4; i++) begin
        s_sh[i]   <= '0;
        vol_sh[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: if (tick) begin
          // Flipping the MSB of offset-binary gives dac - 128 in two's complement.
          s_sh[0]   <= mix.dac0 ^ 8'h80;
          s_sh[1]   <= mix.dac1 ^ 8'h80;
          s_sh[2]   <= mix.dac2 ^ 8'h80;
          s_sh[3]   <= mix.dac3 ^ 8'h80;
          vol_sh[0] <= mix.vol0;
          vol_sh[1] <= mix.vol1;
          vol_sh[2] <= mix.vol2;
          vol_sh[3] <= mix.vol3;
          acc_l     <= '0;
          acc_r     <= '0;
          ch        <= '0;
          bit_idx   <= '0;
        end
        MUL: begin
          if (add_en) begin
            if (!ch[1]) acc_l <= acc_l + addend;
            else        acc_r <= acc_r + addend;
          end
          if (bit_idx == 3'd5) begin
            bit_idx <= '0;
            ch      <= ch + 2'd1;
          end else begin
            bit_idx <= bit_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      pcm_l_q <= '0;
      pcm_r_q <= '0;
    end else if (state == UPDATE) begin
      pcm_l_q <= mix.ena ? acc_l[14:0] : 15'sd0;
      pcm_r_q <= mix.ena ? acc_r[14:0] : 15'sd0;
    end
  end

  // pcm + 16384 is the same as inverting the sign bit.
  assign u_l = {~pcm_l_q[14], pcm_l_q[13:0]};
  assign u_r = {~pcm_r_q[14], pcm_r_q[13:0]};

  always_ff @(posedge clk32) begin
    if (rst) begin
      sd_acc_l <= '0;
      sd_acc_r <= '0;
      dac_l_q  <= 1'b0;
      dac_r_q  <= 1'b0;
    end else begin
      {dac_l_q, sd_acc_l} <= {1'b0, sd_acc_l} + {1'b0, u_l};
      {dac_r_q, sd_acc_r} <= {1'b0, sd_acc_r} + {1'b0, u_r};
    end
  end

  assign mix.pcm_l        = pcm_l_q;
  assign mix.pcm_r        = pcm_r_q;
  assign mix.sample_valid = (state == UPDATE);
  assign mix.busy         = (state != IDLE);
  assign mix.dac_l        = dac_l_q;
  assign mix.dac_r        = dac_r_q;

endmodule
